// File: rtl/stopwatch_counter_if.sv
// Key inputs and display-side outputs of the seconds stopwatch.
// master drives the raw keys; slave is the stopwatch itself.
interface stopwatch_counter_if;
  logic       key_start_n;
  logic       key_clear_n;
  logic [6:0] count;
  logic       running;
  logic       tick;

  modport master (
    output key_start_n,
    output key_clear_n,
    input  count,
    input  running,
    input  tick
  );

  modport slave (
    input  key_start_n,
    input  key_clear_n,
    output count,
    output running,
    output tick
  );
endinterface

// File: rtl/stopwatch_counter.sv
// Seconds stopwatch: debounced start/stop and clear keys, prescaled 1 Hz tick, 7-bit count.
// Define STOPWATCH_OVERRANGE_EN to count past 99 up to 127 (auto-stop at 127) instead of wrapping.
module stopwatch_counter #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic                clk,
  input  logic                rst_n,
  stopwatch_counter_if.slave  sw
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX    = DW'(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);

  localparam int KEY_START = 0;
  localparam int KEY_CLEAR = 1;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  logic [1:0] key_raw;
  logic [1:0] press;

  assign key_raw = {sw.key_clear_n, sw.key_start_n};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      logic          sync1_reg;
      logic          sync2_reg;
      logic [1:0]    prime_reg;
      logic          armed_reg;
      logic [DW-1:0] deb_cnt_reg;
      logic          press_reg;

      // A key is only armed after a genuine synchronized-high sample, so a key
      // held through reset must be released before it can fire.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg   <= 1'b1;
          sync2_reg   <= 1'b1;
          prime_reg   <= 2'b00;
          armed_reg   <= 1'b0;
          deb_cnt_reg <= '0;
          press_reg   <= 1'b0;
        end else begin
          sync1_reg <= key_raw[gi];
          sync2_reg <= sync1_reg;
          prime_reg <= {prime_reg[0], 1'b1};
          if (sync2_reg && prime_reg[1]) begin
            armed_reg <= 1'b1;
          end
          if (sync2_reg) begin
            deb_cnt_reg <= '0;
          end else if (deb_cnt_reg != DEB_MAX) begin
            deb_cnt_reg <= deb_cnt_reg + 1'b1;
          end
          press_reg <= armed_reg && !sync2_reg && (deb_cnt_reg == DEB_LAST);
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  state_t        state_reg;
  logic [PW-1:0] presc_reg;
  logic [6:0]    count_reg;
  logic          running_reg;
  logic          tick_reg;
  logic          hold_max;

`ifdef STOPWATCH_OVERRANGE_EN
  assign hold_max = (count_reg == 7'd127);
`else
  assign hold_max = 1'b0;
`endif

  // Clear outranks start; a start press on the same edge is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= STOPPED;
      presc_reg   <= '0;
      count_reg   <= '0;
      running_reg <= 1'b0;
      tick_reg    <= 1'b0;
    end else begin
      tick_reg <= 1'b0;
      if (press[KEY_CLEAR]) begin
        state_reg   <= STOPPED;
        running_reg <= 1'b0;
        count_reg   <= '0;
        presc_reg   <= '0;
      end else if (press[KEY_START]) begin
        if (state_reg == STOPPED) begin
          state_reg   <= RUNNING;
          running_reg <= 1'b1;
        end else begin
          state_reg   <= STOPPED;
          running_reg <= 1'b0;
        end
      end else if (state_reg == RUNNING && !hold_max) begin
        if (presc_reg == PRESC_LAST) begin
          presc_reg <= '0;
          tick_reg  <= 1'b1;
`ifdef STOPWATCH_OVERRANGE_EN
          count_reg <= count_reg + 7'd1;
          if (count_reg == 7'd126) begin
            state_reg   <= STOPPED;
            running_reg <= 1'b0;
          end
`else
          count_reg <= (count_reg == 7'd99) ? 7'd0 : count_reg + 7'd1;
`endif
        end else begin
          presc_reg <= presc_reg + 1'b1;
        end
      end
    end
  end

  assign sw.count   = count_reg;
  assign sw.running = running_reg;
  assign sw.tick    = tick_reg;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Randomized bench for stopwatch_counter against a cycle-level behavioural model.
// Honours STOPWATCH_OVERRANGE_EN the same way the design does.
module tb_stopwatch_counter;

  localparam int TD = 5;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stopwatch_counter_if sw_if ();

  stopwatch_counter #(
    .TICK_DIV   (TD),
    .DEB_CYCLES (DB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw_if)
  );

  int checks = 0;
  int errors = 0;

  // Model: a press is a low run of exactly DB samples, preceded by a high
  // sample since reset, and takes effect three edges after its last sample.
  bit m_running;
  int m_count;
  int m_presc;
  bit m_tick;
  int run_s, run_c;
  bit hh_s, hh_c;
  bit [2:0] due_s, due_c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_running = 0; m_count = 0; m_presc = 0; m_tick = 0;
    run_s = 0; run_c = 0; hh_s = 0; hh_c = 0;
    due_s = '0; due_c = '0;
  endtask

  task automatic model_edge(input bit ks, input bit kc);
    bit ev_s, ev_c, new_s, new_c;
    ev_s = due_s[2];
    ev_c = due_c[2];
    new_s = 0;
    new_c = 0;
    if (ks) begin run_s = 0; hh_s = 1; end
    else begin run_s++; new_s = hh_s && (run_s == DB); end
    if (kc) begin run_c = 0; hh_c = 1; end
    else begin run_c++; new_c = hh_c && (run_c == DB); end
    due_s = {due_s[1:0], new_s};
    due_c = {due_c[1:0], new_c};

    m_tick = 0;
    if (ev_c) begin
      m_running = 0; m_count = 0; m_presc = 0;
    end else if (ev_s) begin
      m_running = !m_running;
    end else if (m_running && m_count != 127) begin
      m_presc++;
      if (m_presc == TD) begin
        m_presc = 0;
        m_tick = 1;
`ifdef STOPWATCH_OVERRANGE_EN
        m_count++;
        if (m_count == 127) m_running = 0;
`else
        m_count = (m_count + 1) % 100;
`endif
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(sw_if.key_start_n, sw_if.key_clear_n);
    @(negedge clk);
    check("count", 32'(sw_if.count), 32'(m_count));
    check("running", 32'(sw_if.running), 32'(m_running));
    check("tick", 32'(sw_if.tick), 32'(m_tick));
  endtask

  task automatic drive(input bit ks, input bit kc, input int n);
    sw_if.key_start_n = ks;
    sw_if.key_clear_n = kc;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input bit ks);
    rst_n = 1'b0;
    sw_if.key_start_n = ks;
    sw_if.key_clear_n = 1'b1;
    #1;
    check("rst_count", 32'(sw_if.count), 32'd0);
    check("rst_running", 32'(sw_if.running), 32'd0);
    check("rst_tick", 32'(sw_if.tick), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    bit ks;
    sw_if.key_start_n = 1'b1;
    sw_if.key_clear_n = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset(1'b1);
    $display("txn reset idle 50");
    drive(1, 1, 50);

    $display("txn start + long run");
    drive(0, 1, DB + 2);
    drive(1, 1, 700);
    $display("txn start at end of long run, count=%0d", m_count);
    drive(0, 1, DB + 2);
    drive(1, 1, 30);
    $display("txn clear");
    drive(1, 0, DB + 1);
    drive(1, 1, 5);

    for (int t = 0; t < 160; t++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: begin
          $display("txn start press count=%0d running=%0d", m_count, m_running);
          drive(0, 1, DB + $urandom_range(0, 6));
          drive(1, 1, $urandom_range(1, 4));
        end
        3: begin
          $display("txn bounce start");
          drive(0, 1, $urandom_range(1, DB - 1));
          drive(1, 1, $urandom_range(1, 3));
        end
        4: begin
          $display("txn clear press count=%0d", m_count);
          drive(1, 0, DB + $urandom_range(0, 3));
          drive(1, 1, $urandom_range(1, 4));
        end
        5: begin
          $display("txn clear+start together count=%0d", m_count);
          drive(0, 0, DB + $urandom_range(0, 3));
          drive(1, 1, $urandom_range(1, 4));
        end
        6: begin
          $display("txn long idle");
          drive(1, 1, $urandom_range(20, 300));
        end
        7: begin
          ks = 1'($urandom_range(0, 1));
          $display("txn async reset key_start_n=%0d", ks);
          do_reset(ks);
          drive(ks, 1, DB + 5);
          drive(1, 1, 2);
        end
        default: begin
          $display("txn short idle");
          drive(1, 1, $urandom_range(1, 20));
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
